// File: rtl/demux_route_pkg.sv
// rtl/demux_route_pkg.sv - shared types and constants for the demux route controller
package demux_route_pkg;

    localparam int SEL_W  = 3;
    localparam int NUM_CH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_e;

    // Bit-counter width; a 1-bit payload still needs a 1-bit counter.
    function automatic int cnt_bits(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_shreg.sv
// rtl/piso_shreg.sv - parallel-load, shift-left register with MSB serial output
module piso_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] din_i,
    output logic         msb_o
);

    logic [W-1:0] shreg_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (load_i) begin
            shreg_q <= din_i;
        end else if (shift_i) begin
            shreg_q <= shreg_q << 1;
        end
    end

    assign msb_o = shreg_q[W-1];

endmodule

// File: rtl/demux_route_ctrl.sv
// rtl/demux_route_ctrl.sv - serialises a word MSB-first onto dout with a stable demux select
// Optional trailing even-parity bit: DEMUX_ROUTE_PARITY_EN
module demux_route_ctrl
    import demux_route_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SEL_W-1:0]  in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              dout,
    output logic [SEL_W-1:0]  sel,
    output logic              dout_valid,
    output logic              dout_last,
    output logic              done,
    output logic [CNT_W-1:0]  words_sent
);

    localparam int CB = cnt_bits(DATA_W);

    state_e           state_q, state_d;
    logic [CB-1:0]    bit_cnt_q, bit_cnt_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] words_q, words_d;
    logic             load, shift, msb;
`ifdef DEMUX_ROUTE_PARITY_EN
    logic             parity_q, parity_d;
`endif

    piso_shreg #(.W(DATA_W)) u_shreg (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .shift_i (shift),
        .din_i   (in_data),
        .msb_o   (msb)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            sel_q     <= '0;
            done_q    <= 1'b0;
            words_q   <= '0;
`ifdef DEMUX_ROUTE_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sel_q     <= sel_d;
            done_q    <= done_d;
            words_q   <= words_d;
`ifdef DEMUX_ROUTE_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sel_d     = sel_q;
        done_d    = 1'b0;
        words_d   = words_q;
        load      = 1'b0;
        shift     = 1'b0;
`ifdef DEMUX_ROUTE_PARITY_EN
        parity_d  = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load      = 1'b1;
                    sel_d     = in_addr;
                    bit_cnt_d = CB'(DATA_W - 1);
                    state_d   = SHIFT;
`ifdef DEMUX_ROUTE_PARITY_EN
                    parity_d  = ^in_data;
`endif
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (bit_cnt_q == '0) begin
`ifdef DEMUX_ROUTE_PARITY_EN
                    state_d = PAR;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
                    words_d = words_q + CNT_W'(1);
`endif
                end else begin
                    bit_cnt_d = bit_cnt_q - CB'(1);
                end
            end
`ifdef DEMUX_ROUTE_PARITY_EN
            PAR: begin
                state_d = IDLE;
                done_d  = 1'b1;
                words_d = words_q + CNT_W'(1);
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign sel        = sel_q;
    assign done       = done_q;
    assign words_sent = words_q;

`ifdef DEMUX_ROUTE_PARITY_EN
    assign dout       = (state_q == SHIFT) ? msb : ((state_q == PAR) ? parity_q : 1'b0);
    assign dout_valid = (state_q == SHIFT) || (state_q == PAR);
    assign dout_last  = (state_q == PAR);
`else
    assign dout       = (state_q == SHIFT) ? msb : 1'b0;
    assign dout_valid = (state_q == SHIFT);
    assign dout_last  = (state_q == SHIFT) && (bit_cnt_q == '0);
`endif

endmodule

// File: tb/tb_demux_route_ctrl.sv
// tb/tb_demux_route_ctrl.sv - scoreboard bench for demux_route_ctrl
module tb_demux_route_ctrl;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
`ifdef DEMUX_ROUTE_PARITY_EN
    localparam int PAR_EN = 1;
`else
    localparam int PAR_EN = 0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_addr;
    logic [DATA_W-1:0] in_data;
    logic              dout;
    logic [2:0]        sel;
    logic              dout_valid;
    logic              dout_last;
    logic              done;
    logic [CNT_W-1:0]  words_sent;

    demux_route_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .dout       (dout),
        .sel        (sel),
        .dout_valid (dout_valid),
        .dout_last  (dout_last),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       d;
        logic [2:0] s;
        logic       l;
    } bit_t;

    bit_t exp_bits[$];
    int   exp_done[$];
    int   exp_words = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   done_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expected bit per valid cycle and one expected count per done pulse.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_vs_busy", int'(in_ready), int'(!dout_valid));
            if (dout_valid) begin
                if (exp_bits.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    bit_t e;
                    e = exp_bits.pop_front();
                    chk("dout", int'(dout), int'(e.d));
                    chk("sel", int'(sel), int'(e.s));
                    chk("dout_last", int'(dout_last), int'(e.l));
                end
            end else begin
                chk("idle_dout", int'({dout, dout_last}), 0);
            end
            if (done) begin
                done_cyc = cyc;
                if (exp_done.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    int w;
                    w = exp_done.pop_front();
                    chk("words_sent", int'(words_sent), w);
                end
            end
        end
    end

    task automatic send(input logic [2:0] a, input logic [DATA_W-1:0] d, input bit hold);
        bit   ok;
        bit_t b;
        in_addr  = a;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            b.d = d[i];
            b.s = a;
            b.l = (i == 0) && (PAR_EN == 0);
            exp_bits.push_back(b);
        end
        if (PAR_EN != 0) begin
            b.d = ^d;
            b.s = a;
            b.l = 1'b1;
            exp_bits.push_back(b);
        end
        exp_words = (exp_words + 1) % (1 << CNT_W);
        exp_done.push_back(exp_words);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("accept_timeout", 0, 1);
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int latency);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({nm, "_timeout"}, 0, 1);
        else if (latency > 0) chk({nm, "_latency"}, cyc - acc_cyc, latency);
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_addr  = 3'b010;
        in_data  = 8'h3C;

        // Reset held two cycles with in_valid asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", int'({dout, sel, dout_valid, dout_last, done}), 0);
        chk("rst_words", int'(words_sent), 0);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;

        // Single word
        send(3'b101, 8'hA5, 1'b0);
        wait_done("single", DATA_W + 1 + PAR_EN);
        repeat (2) @(posedge clk);
        #1;

        // Back-to-back with in_valid held: second accept lands in the done cycle
        send(3'b000, 8'hFF, 1'b1);
        send(3'b111, 8'h01, 1'b0);
        chk("b2b_accept_in_done_cycle", acc_cyc, done_cyc);
        wait_done("b2b", DATA_W + 1 + PAR_EN);
        repeat (2) @(posedge clk);
        #1;

        // Busy ignore: pulse another word during bit 4
        send(3'b110, 8'hC3, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        in_addr  = 3'b010;
        in_data  = 8'h3C;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_done("busy", 0);
        @(negedge clk);
        chk("busy_words", int'(words_sent), 4);
        repeat (2) @(posedge clk);
        #1;

`ifdef DEMUX_ROUTE_PARITY_EN
        send(3'b001, 8'hA5, 1'b0);
        wait_done("par_a5", DATA_W + 2);
        send(3'b100, 8'h07, 1'b0);
        wait_done("par_07", DATA_W + 2);
        repeat (2) @(posedge clk);
        #1;
`endif

        // Reset after three bits of a word
        send(3'b101, 8'hA5, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_bits.delete();
        exp_done.delete();
        exp_words = 0;
        @(negedge clk);
        chk("midrst_valid", int'(dout_valid), 0);
        chk("midrst_sel", int'(sel), 0);
        chk("midrst_words", int'(words_sent), 0);
        chk("midrst_done", int'(done), 0);
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("leftover_bits", exp_bits.size(), 0);
        chk("leftover_done", exp_done.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
